// File: rtl/compute_sad_pkg.sv
// compute_sad_pkg: shared sizing helpers for the SAD disparity search
package compute_sad_pkg;
  function automatic int clog2(input longint x);
    int r = 0;
    longint v = 1;
    while (v < x) begin
      v = v * 2;
      r++;
    end
    return r;
  endfunction
  function automatic int sad_n(input int win, input int max_disp);
    return win - max_disp + 1;
  endfunction
  function automatic int sad_w(input int win, input int max_disp, input int data_size);
    return clog2(longint'(sad_n(win, max_disp)) * ((longint'(1) << data_size) - 1) + 1);
  endfunction
  function automatic int disp_w(input int max_disp);
    return max_disp > 1 ? clog2(longint'(max_disp)) : 1;
  endfunction
  localparam int DEF_N = sad_n(15, 3);
  localparam int DEF_SAD_W = sad_w(15, 3, 8);
  localparam int DEF_DISP_W = disp_w(3);
endpackage

// File: rtl/sad_argmin.sv
// sad_argmin: SAD for each candidate disparity of one column, lowest-d minimum wins
module sad_argmin
  import compute_sad_pkg::*;
#(
  parameter int WIN       = 15,
  parameter int DATA_SIZE = 8,
  parameter int MAX_DISP  = 3
) (
  input  logic [DATA_SIZE*WIN-1:0] cur_i,
  input  logic [DATA_SIZE*WIN-1:0] prev_i,
  output logic [DATA_SIZE-1:0]     best_o
);
  localparam int SW = sad_w(WIN, MAX_DISP, DATA_SIZE);
  localparam int DW = disp_w(MAX_DISP);
  logic [SW-1:0] acc, best_sad;
  logic [DATA_SIZE-1:0] a, b;
  logic [DW-1:0] best;
  always_comb begin
    acc = '0;
    best_sad = '0;
    best = '0;
    a = '0;
    b = '0;
    for (int d = 0; d < MAX_DISP; d++) begin
      acc = '0;
      for (int i = MAX_DISP - 1; i < WIN; i++) begin
        a = cur_i[i*DATA_SIZE +: DATA_SIZE];
        b = prev_i[(i-d)*DATA_SIZE +: DATA_SIZE];
        acc = acc + SW'(a > b ? a - b : b - a);
      end
      if (d == 0 || acc < best_sad) begin
        best_sad = acc;
        best = DW'(d);
      end
    end
  end
  assign best_o = DATA_SIZE'(best);
endmodule

// File: rtl/compute_sad.sv
// compute_sad: registers left/right rows and outputs the best disparity per column
module compute_sad
  import compute_sad_pkg::*;
#(
  parameter int WIN       = 15,
  parameter int DATA_SIZE = 8,
  parameter int IMG_W     = 1,
  parameter int MAX_DISP  = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_SIZE*IMG_W*WIN-1:0] input_array,
  output logic [DATA_SIZE*IMG_W-1:0]     output_row
);
  localparam int RW = DATA_SIZE * WIN;
  logic [DATA_SIZE*IMG_W*WIN-1:0] cur_q, prev_q;
  logic [DATA_SIZE*IMG_W-1:0] out_d, out_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= '0;
      prev_q <= '0;
      out_q <= '0;
    end else begin
      cur_q <= input_array;
      prev_q <= cur_q;
      out_q <= out_d;
    end
  end
  for (genvar c = 0; c < IMG_W; c++) begin : g_col
    sad_argmin #(.WIN(WIN), .DATA_SIZE(DATA_SIZE), .MAX_DISP(MAX_DISP)) u_argmin (
      .cur_i (cur_q[c*RW +: RW]),
      .prev_i(prev_q[c*RW +: RW]),
      .best_o(out_d[c*DATA_SIZE +: DATA_SIZE])
    );
  end
  assign output_row = out_q;
endmodule

// File: tb/tb_compute_sad.sv
// tb_compute_sad: directed and random checks of compute_sad against a row-history model
module tb_compute_sad;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [239:0] in_w2 = '0;
  logic [7:0] out_def;
  logic [15:0] out_w2;
  logic [119:0] m_cur [2];
  logic [119:0] m_prev [2];
  logic [239:0] last_row = '0;
  logic [239:0] rnd_row;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  compute_sad u_def (.clk(clk), .rst(rst), .input_array(in_w2[119:0]), .output_row(out_def));
  compute_sad #(.IMG_W(2)) u_w2 (.clk(clk), .rst(rst), .input_array(in_w2), .output_row(out_w2));

  // Disparity whose SAD over window pixels 2..14 is smallest; first minimum kept.
  function automatic int best_d(input logic [119:0] c, input logic [119:0] p);
    int best = 0;
    int best_s = 0;
    for (int d = 0; d < 3; d++) begin
      int s = 0;
      for (int i = 2; i < 15; i++) begin
        int a = int'(c[i*8 +: 8]);
        int b = int'(p[(i-d)*8 +: 8]);
        s += (a > b) ? a - b : b - a;
      end
      if (d == 0 || s < best_s) begin
        best_s = s;
        best = d;
      end
    end
    return best;
  endfunction

  function automatic logic [239:0] mk(input int s0, input int s1);
    logic [239:0] r = '0;
    for (int i = 0; i < 15; i++) begin
      r[i*8 +: 8] = 8'((i - s0) > 0 ? i - s0 : 0);
      r[(15+i)*8 +: 8] = 8'((i - s1) > 0 ? i - s1 : 0);
    end
    return r;
  endfunction

  function automatic logic [239:0] fill(input logic [7:0] v);
    return {30{v}};
  endfunction

  task automatic step(input logic [239:0] row, input logic r, input string tag);
    logic [15:0] exp;
    in_w2 = row;
    rst = r;
    @(posedge clk);
    exp = r ? 16'h0 : {8'(best_d(m_cur[1], m_prev[1])), 8'(best_d(m_cur[0], m_prev[0]))};
    for (int c = 0; c < 2; c++) begin
      m_prev[c] = r ? '0 : m_cur[c];
      m_cur[c] = r ? '0 : row[c*120 +: 120];
    end
    #1;
    tests++;
    assert (out_w2 === exp) else begin
      fails++;
      $error("FAIL %s w2 observed=%h expected=%h", tag, out_w2, exp);
    end
    tests++;
    assert (out_def === exp[7:0]) else begin
      fails++;
      $error("FAIL %s def observed=%h expected=%h", tag, out_def, exp[7:0]);
    end
  endtask

  task automatic chk_const(input logic [15:0] e, input string tag);
    tests++;
    assert (out_w2 === e) else begin
      fails++;
      $error("FAIL %s const_w2 observed=%h expected=%h", tag, out_w2, e);
    end
    tests++;
    assert (out_def === e[7:0]) else begin
      fails++;
      $error("FAIL %s const_def observed=%h expected=%h", tag, out_def, e[7:0]);
    end
  endtask

  initial begin
    m_cur[0] = '0; m_cur[1] = '0; m_prev[0] = '0; m_prev[1] = '0;
    step(mk(0, 0), 1'b1, "reset0");
    step(mk(0, 0), 1'b1, "reset1");
    chk_const(16'h0000, "reset_state");
    step(mk(0, 0), 1'b0, "ramp0");
    step(mk(0, 0), 1'b0, "ramp1");
    step(mk(0, 0), 1'b0, "ramp2");
    chk_const(16'h0000, "ramp_hold");
    step(mk(0, 0), 1'b0, "sh1_a");
    step(mk(1, 1), 1'b0, "sh1_b");
    step(mk(1, 1), 1'b0, "sh1_c");
    chk_const(16'h0101, "shift1");
    step(mk(0, 0), 1'b0, "sh2_a");
    step(mk(2, 2), 1'b0, "sh2_b");
    step(mk(2, 2), 1'b0, "sh2_c");
    chk_const(16'h0202, "shift2");
    step(fill(8'h00), 1'b0, "sat_a");
    step(fill(8'hff), 1'b0, "sat_b");
    step(fill(8'hff), 1'b0, "sat_c");
    chk_const(16'h0000, "saturate_tie");
    step(mk(0, 0), 1'b0, "col_a");
    step(mk(1, 2), 1'b0, "col_b");
    step(mk(1, 2), 1'b0, "col_c");
    chk_const(16'h0201, "col_indep");
    step(mk(0, 0), 1'b0, "mrst_a");
    step(mk(2, 2), 1'b0, "mrst_b");
    step(mk(2, 2), 1'b0, "mrst_c");
    chk_const(16'h0202, "pre_reset");
    step(mk(0, 0), 1'b1, "mrst_assert");
    chk_const(16'h0000, "mid_reset");
    step(mk(2, 2), 1'b0, "mrst_release");
    chk_const(16'h0000, "post_release");
    last_row = mk(2, 2);
    for (int n = 0; n < 300; n++) begin
      for (int c = 0; c < 2; c++) begin
        int s = int'($urandom_range(0, 2));
        bit shifted = $urandom_range(0, 1) == 1;
        for (int i = 0; i < 15; i++) begin
          int j = (i - s) > 0 ? i - s : 0;
          rnd_row[(c*15+i)*8 +: 8] = shifted ? last_row[(c*15+j)*8 +: 8] : 8'($urandom_range(0, 255));
        end
      end
      last_row = rnd_row;
      step(rnd_row, $urandom_range(0, 29) == 0, "random");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/compute_sad.md
COMPUTE_SAD -- requirements
Module: compute_SAD

Interface
REQ-001 SHALL have parameter WIN, default 15: number of pixels per window row.
REQ-002 SHALL have parameter DATA_SIZE, default 8: pixel and disparity-field width in bits.
REQ-003 SHALL have parameter IMG_W, default 1: number of independent columns processed in parallel.
REQ-004 SHALL have parameter MAX_DISP, default 3: number of candidate disparities, 0..MAX_DISP-1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port input_array, input, DATA_SIZE*IMG_W*WIN bits: packed pixels; pixel i of column c is at bits [(c*WIN+i)*DATA_SIZE +: DATA_SIZE], unsigned.
REQ-008 SHALL have port output_row, output, DATA_SIZE*IMG_W bits: best disparity of column c at bits [c*DATA_SIZE +: DATA_SIZE].
REQ-009 SHALL require 1 <= MAX_DISP <= WIN and MAX_DISP <= 2^DATA_SIZE; other parameter combinations are unsupported.

Function
REQ-010 SHALL sample input_array into register cur on every rising clk edge, with no valid/enable handshake.
REQ-011 SHALL copy the old cur into register prev on the same edge; prev is the right-image reference row and cur is the left-image row.
REQ-012 SHALL, per column c and candidate d, compute SAD(c,d) = sum over i = MAX_DISP-1..WIN-1 of |cur[c][i] - prev[c][i-d]|, giving N = WIN-MAX_DISP+1 terms, all indices in range.
REQ-013 SHALL take absolute differences on unsigned values without wrap.
REQ-014 SHALL size accumulators at clog2(N*(2^DATA_SIZE-1)+1) bits (12 bits for the defaults), so no overflow is possible.
REQ-015 SHALL select per column the d with minimum SAD, using strict less-than compared in ascending d, so ties resolve to the lowest d.
REQ-016 SHALL register the selected d, zero-extended to DATA_SIZE, into output_row on the rising edge.
REQ-017 SHALL have 2-edge latency: output_row after edge k+1 reflects cur = input sampled at edge k and prev = input sampled at edge k-1.
REQ-018 SHALL process columns fully independently, with no cross-column pixel use.
REQ-019 SHALL keep output_row valid only after two post-reset edges; earlier outputs follow from the zeroed registers and are defined (0).

Reset
REQ-020 SHALL, while rst=1 at a rising edge, clear cur, prev and output_row to 0, with rst taking precedence over sampling.
REQ-021 SHALL treat rst asserted mid-operation the same way: output_row = 0 after that edge and pipeline history discarded.

Structure
REQ-022 SHALL place the SAD width, N and disparity-index width constants, plus the clog2 helper, in the shared package compute_sad_pkg.
REQ-023 SHALL use one sub-module, sad_argmin, instantiated IMG_W times: inputs are one column of cur and prev, output is the best d.
REQ-024 SHALL build the top level only from the cur/prev/output registers and the generate loop over columns.

Verification
REQ-025 SHALL pass: defaults, input held at ramp 0..14 for 3 edges after reset -> output_row = 0 (SADs 0, 13, 26).
REQ-026 SHALL pass: ramp 0..14 at edge k, then x[i] = max(i-1, 0) at edge k+1 -> output_row = 1 after edge k+2.
REQ-027 SHALL pass: ramp at edge k, then x[i] = max(i-2, 0) at edge k+1 -> output_row = 2.
REQ-028 SHALL pass: all-0 row at edge k, then all-255 row at edge k+1 -> all SADs 3315 (tie, no overflow), output_row = 0.
REQ-029 SHALL pass: IMG_W=2, column 0 shifted by 1 and column 1 shifted by 2 -> output_row = 16'h0201.
REQ-030 SHALL pass: rst asserted while output_row = 2 -> output_row = 0 after that edge, and 0 again one edge after release even with shifted data applied.
